store_queue: RTL and testbench
==============================

Name: store_queue

Overview:
- Circular in-order buffer for store instructions; the write-side counterpart to the load queue in the Jellycore LSU.
- Allocates an entry at dispatch and captures address and data independently from execution.
- Entries are marked committed in program order on ROB retirement; committed entries drain oldest-first to the data-memory write port over a valid/ready handshake.
- Sits between dispatch/execute/ROB and the D-cache write port.

Parameters:
SQ_SIZE, 8, number of entries; power of two, >=2
ADDR_WIDTH, 32, store address width
DATA_WIDTH, 32, store data width
ROB_SEL, 6, ROB index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dispatch_valid  in  1  allocate new store entry
dispatch_rob_idx  in  ROB_SEL  ROB tag of the store
dispatch_ready  out  1  =!sq_full; dispatch accepted only when high
dispatch_sq_idx  out  log2(SQ_SIZE)  index allocated this cycle (=tail)
addr_valid  in  1  address result available
addr_sq_idx  in  log2(SQ_SIZE)  target entry of address
addr_in  in  ADDR_WIDTH  computed address
data_valid  in  1  store data available
data_sq_idx  in  log2(SQ_SIZE)  target entry of data
data_in  in  DATA_WIDTH  store data
commit_valid  in  1  ROB retires the oldest uncommitted store
commit_ready  out  1  entry at commit_ptr is valid, addr_ok, data_ok, and not committed
flush  in  1  squash all uncommitted entries
mem_req_valid  out  1  head entry is committed and drainable
mem_req_addr  out  ADDR_WIDTH  head address
mem_req_data  out  DATA_WIDTH  head data
mem_req_rob_idx  out  ROB_SEL  head ROB tag (debug/trace)
mem_req_ready  in  1  memory accepts write
ld_valid  in  1  forwarding lookup request (see feature)
ld_addr  in  ADDR_WIDTH  load address for lookup
fwd_hit  out  1  forwarding match
fwd_data  out  DATA_WIDTH  forwarded data
sq_full  out  1  count==SQ_SIZE
sq_empty  out  1  count==0

Behaviour:
- Per-entry state: valid, addr_ok, data_ok, committed, addr, data, rob_idx.
- Pointers: head (oldest), commit_ptr (oldest uncommitted), tail (next free). count is log2(SQ_SIZE)+1 bits. All pointers wrap modulo SQ_SIZE.
- Reset: every entry has valid=0; head=commit_ptr=tail=0; count=0.
  - Outputs after reset: sq_empty=1, sq_full=0, dispatch_ready=1, commit_ready=0, mem_req_valid=0, fwd_hit=0.
  - Data outputs at reset are 0.
  - Reset mid-drain drops all entries with no further mem_req.
- Status outputs are combinational from registered state (no stale flags):
  - sq_full, sq_empty, dispatch_ready, commit_ready, mem_req_*.
- Dispatch: when dispatch_valid&&dispatch_ready, entry[tail] gets valid=1, flags cleared, rob_idx captured; tail+1; visible next cycle.
- Address/data update:
  - On addr_valid, write entry[addr_sq_idx].addr and set addr_ok, only if the entry is valid at the start of the cycle; otherwise ignore.
  - Data updates follow the same rule.
  - Address and data to the same entry in one cycle: both are applied.
  - Re-write of an already-ok field overwrites it (no error).
- Commit:
  - Accepted when commit_valid&&commit_ready: sets committed, commit_ptr+1.
  - commit_valid while commit_ready=0 is ignored (ROB guarantees ordering).
- Drain:
  - mem_req_valid = entry[head].valid && committed.
  - A committed entry is always addr_ok and data_ok.
  - On mem_req_valid&&mem_req_ready: clear valid, head+1.
  - mem_req_* stay stable while valid && !ready.
  - Latency: commit in cycle N gives mem_req_valid in N+1 at the earliest.
- Flush:
  - tail<=commit_ptr; entries commit_ptr..tail-1 get valid=0; count becomes committed-entry count (minus any drain in the same cycle).
  - Flush overrides dispatch, commit, and addr/data updates in the same cycle; drain proceeds.
- Simultaneous dispatch+drain: count unchanged.
- Full: dispatch is blocked even if a drain frees a slot in the same cycle.

Optional Feature:
- Macro: STQ_FWD_EN.
- When defined, store-to-load forwarding is enabled (combinational):
  - When ld_valid, scan valid entries with addr_ok&&data_ok and addr==ld_addr (exact match).
  - The youngest match (nearest to tail) drives fwd_hit=1 and fwd_data.
  - Otherwise fwd_hit=0, fwd_data=0.
- When undefined:
  - ld_valid/ld_addr are ignored.
  - fwd_hit is tied 0 and fwd_data is tied 0.
  - No comparator logic is generated.

Test Plan:
- Reset, then dispatch 8 stores (rob 0..7) with no drain -> dispatch_sq_idx 0..7, sq_full=1 after the 8th, dispatch_ready=0, 9th dispatch ignored.
- Dispatch idx0; addr 0x100 and data 0xDEAD in the same cycle; commit; mem_req_ready=0 for 3 cycles, then 1 -> mem_req_valid held with addr 0x100 / data 0xDEAD, deallocated on ready, sq_empty=1.
- Dispatch 3 stores, commit first only, flush -> tail=1, count=1, entry0 still drains, later dispatch gets idx1.
- Wrap: 12 dispatch/commit/drain cycles with SQ_SIZE=8 -> indices wrap 7->0, memory writes in program order, count never exceeds 8.
- commit_valid on an entry lacking data -> ignored, commit_ptr unchanged; after data arrives, commit accepted.
- STQ_FWD_EN: stores to 0x40 with data 0x11 (older) and 0x22 (younger); ld_addr=0x40 -> fwd_hit=1, fwd_data=0x22. With the macro undefined -> fwd_hit=0.

Source files
------------

// File: rtl/store_queue.sv
// Store queue: in-order circular buffer of stores, committed by the ROB and drained oldest-first to the D-cache.
// Optional macro STQ_FWD_EN enables combinational store-to-load forwarding.
module store_queue #(
    parameter int SQ_SIZE    = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_SEL    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_valid,
    input  logic [ROB_SEL-1:0]         dispatch_rob_idx,
    output logic                       dispatch_ready,
    output logic [$clog2(SQ_SIZE)-1:0] dispatch_sq_idx,
    input  logic                       addr_valid,
    input  logic [$clog2(SQ_SIZE)-1:0] addr_sq_idx,
    input  logic [ADDR_WIDTH-1:0]      addr_in,
    input  logic                       data_valid,
    input  logic [$clog2(SQ_SIZE)-1:0] data_sq_idx,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       commit_valid,
    output logic                       commit_ready,
    input  logic                       flush,
    output logic                       mem_req_valid,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr,
    output logic [DATA_WIDTH-1:0]      mem_req_data,
    output logic [ROB_SEL-1:0]         mem_req_rob_idx,
    input  logic                       mem_req_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_WIDTH-1:0]      ld_addr,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    output logic                       sq_full,
    output logic                       sq_empty
);
    localparam int IW = $clog2(SQ_SIZE);
    localparam logic [IW:0] CNT_FULL = (IW+1)'(SQ_SIZE);

    logic [SQ_SIZE-1:0]    valid_q, addr_ok_q, data_ok_q, committed_q;
    logic [ADDR_WIDTH-1:0] addr_q [SQ_SIZE];
    logic [DATA_WIDTH-1:0] data_q [SQ_SIZE];
    logic [ROB_SEL-1:0]    rob_q  [SQ_SIZE];
    logic [IW-1:0]         head_q, cmt_q, tail_q, head_d, cmt_d, tail_d;
    logic [IW:0]           count_q, count_d, n_cmt;
    logic                  do_disp, do_cmt, do_drain;

    assign sq_full         = (count_q == CNT_FULL);
    assign sq_empty        = (count_q == '0);
    assign dispatch_ready  = !sq_full;
    assign dispatch_sq_idx = tail_q;
    assign commit_ready    = valid_q[cmt_q] && addr_ok_q[cmt_q] && data_ok_q[cmt_q] && !committed_q[cmt_q];
    assign mem_req_valid   = valid_q[head_q] && committed_q[head_q];
    assign mem_req_addr    = addr_q[head_q];
    assign mem_req_data    = data_q[head_q];
    assign mem_req_rob_idx = rob_q[head_q];

    // Flush outranks dispatch and commit; the drain of an already committed head still goes ahead.
    assign do_disp  = dispatch_valid && dispatch_ready && !flush;
    assign do_cmt   = commit_valid && commit_ready && !flush;
    assign do_drain = mem_req_valid && mem_req_ready;

    always_comb begin
        n_cmt = '0;
        for (int i = 0; i < SQ_SIZE; i++)
            if (valid_q[i] && committed_q[i]) n_cmt = n_cmt + (IW+1)'(1);
        head_d = head_q + IW'(do_drain);
        cmt_d  = cmt_q + IW'(do_cmt);
        if (flush) begin
            tail_d  = cmt_q;
            count_d = n_cmt - (IW+1)'(do_drain);
        end else begin
            tail_d  = tail_q + IW'(do_disp);
            count_d = count_q + (IW+1)'(do_disp) - (IW+1)'(do_drain);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            cmt_q       <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            addr_ok_q   <= '0;
            data_ok_q   <= '0;
            committed_q <= '0;
            for (int i = 0; i < SQ_SIZE; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                rob_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Uncommitted entries are exactly the span commit_ptr..tail-1 that a flush squashes.
            for (int i = 0; i < SQ_SIZE; i++)
                if (flush && valid_q[i] && !committed_q[i]) valid_q[i] <= 1'b0;
            if (do_drain) valid_q[head_q] <= 1'b0;
            if (do_disp) begin
                valid_q[tail_q]     <= 1'b1;
                addr_ok_q[tail_q]   <= 1'b0;
                data_ok_q[tail_q]   <= 1'b0;
                committed_q[tail_q] <= 1'b0;
                rob_q[tail_q]       <= dispatch_rob_idx;
            end
            if (addr_valid && !flush && valid_q[addr_sq_idx]) begin
                addr_q[addr_sq_idx]    <= addr_in;
                addr_ok_q[addr_sq_idx] <= 1'b1;
            end
            if (data_valid && !flush && valid_q[data_sq_idx]) begin
                data_q[data_sq_idx]    <= data_in;
                data_ok_q[data_sq_idx] <= 1'b1;
            end
            if (do_cmt) committed_q[cmt_q] <= 1'b1;
        end
    end

`ifdef STQ_FWD_EN
    logic [IW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (ld_valid) begin
            for (int k = 0; k < SQ_SIZE; k++) begin
                fwd_idx = head_q + IW'(k);
                if (valid_q[fwd_idx] && addr_ok_q[fwd_idx] && data_ok_q[fwd_idx] &&
                    addr_q[fwd_idx] == ld_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[fwd_idx];
                end
            end
        end
    end
`else
    logic unused_ld;
    assign unused_ld = ^{ld_valid, ld_addr};
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_store_queue.sv
// Directed testbench for store_queue: allocation, drain handshake, flush, wrap, commit gating and forwarding.
module tb_store_queue;
    logic        clk, reset;
    logic        dispatch_valid, dispatch_ready;
    logic [5:0]  dispatch_rob_idx;
    logic [2:0]  dispatch_sq_idx, addr_sq_idx, data_sq_idx;
    logic        addr_valid, data_valid, commit_valid, commit_ready, flush;
    logic [31:0] addr_in, data_in, mem_req_addr, mem_req_data, ld_addr, fwd_data;
    logic        mem_req_valid, mem_req_ready, ld_valid, fwd_hit, sq_full, sq_empty;
    logic [5:0]  mem_req_rob_idx;
    int          total, bad;

    store_queue dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_rob_idx(dispatch_rob_idx),
        .dispatch_ready(dispatch_ready), .dispatch_sq_idx(dispatch_sq_idx),
        .addr_valid(addr_valid), .addr_sq_idx(addr_sq_idx), .addr_in(addr_in),
        .data_valid(data_valid), .data_sq_idx(data_sq_idx), .data_in(data_in),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_rob_idx(mem_req_rob_idx), .mem_req_ready(mem_req_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .sq_full(sq_full), .sq_empty(sq_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dispatch_valid = 0; dispatch_rob_idx = 0; addr_valid = 0; addr_sq_idx = 0; addr_in = 0;
        data_valid = 0; data_sq_idx = 0; data_in = 0; commit_valid = 0; flush = 0;
        mem_req_ready = 0; ld_valid = 0; ld_addr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic dispatch(input int rob);
        dispatch_valid = 1; dispatch_rob_idx = 6'(rob);
        tick();
        dispatch_valid = 0;
    endtask

    task automatic write_ad(input int idx, input logic [31:0] a, input logic [31:0] d);
        addr_valid = 1; addr_sq_idx = 3'(idx); addr_in = a;
        data_valid = 1; data_sq_idx = 3'(idx); data_in = d;
        tick();
        addr_valid = 0; data_valid = 0;
    endtask

    task automatic commit_one();
        commit_valid = 1;
        tick();
        commit_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (sq_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", sq_empty); end
        total++; if (sq_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", sq_full); end
        total++; if (dispatch_ready !== 1'b1) begin bad++; $display("FAIL reset_dready: got %b want 1", dispatch_ready); end
        total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL reset_cready: got %b want 0", commit_ready); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_memv: got %b want 0", mem_req_valid); end
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL reset_fwd: got %b want 0", fwd_hit); end
        total++; if (mem_req_addr !== 32'h0 || mem_req_data !== 32'h0) begin bad++;
            $display("FAIL reset_memdata: got %h/%h want 0/0", mem_req_addr, mem_req_data); end
        total++; if (dispatch_sq_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", dispatch_sq_idx); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            total++; if (dispatch_sq_idx !== 3'(i) || dispatch_ready !== 1'b1) begin bad++;
                $display("FAIL fill_idx%0d: got idx %0d rdy %b want idx %0d rdy 1", i, dispatch_sq_idx, dispatch_ready, i); end
            dispatch(i);
        end
        total++; if (sq_full !== 1'b1 || dispatch_ready !== 1'b0) begin bad++;
            $display("FAIL fill_full: got full %b rdy %b want 1 0", sq_full, dispatch_ready); end
        dispatch(63);
        total++; if (sq_full !== 1'b1 || dispatch_sq_idx !== 3'd0) begin bad++;
            $display("FAIL fill_ninth: got full %b idx %0d want 1 0", sq_full, dispatch_sq_idx); end
    endtask

    task automatic test_drain_stall();
        do_reset();
        dispatch(9);
        write_ad(0, 32'h100, 32'hDEAD);
        total++; if (commit_ready !== 1'b1 || mem_req_valid !== 1'b0) begin bad++;
            $display("FAIL stall_precommit: got crdy %b memv %b want 1 0", commit_ready, mem_req_valid); end
        commit_one();
        for (int c = 0; c < 3; c++) begin
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_data !== 32'hDEAD || mem_req_rob_idx !== 6'd9) begin
                bad++; $display("FAIL stall_hold%0d: got v%b %h %h r%0d want v1 100 dead r9", c, mem_req_valid, mem_req_addr, mem_req_data, mem_req_rob_idx); end
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        total++; if (mem_req_valid !== 1'b0 || sq_empty !== 1'b1) begin bad++;
            $display("FAIL stall_dealloc: got memv %b empty %b want 0 1", mem_req_valid, sq_empty); end
        // Reset while a committed store waits at the head.
        dispatch(1);
        write_ad(1, 32'h104, 32'h5);
        commit_one();
        reset = 1;
        #2;
        total++; if (mem_req_valid !== 1'b0 || sq_empty !== 1'b1) begin bad++;
            $display("FAIL stall_reset: got memv %b empty %b want 0 1", mem_req_valid, sq_empty); end
        reset = 0;
        #1;
    endtask

    task automatic test_flush();
        do_reset();
        dispatch(10); dispatch(11); dispatch(12);
        write_ad(0, 32'h200, 32'hA0);
        write_ad(1, 32'h204, 32'hA1);
        commit_one();
        flush = 1; dispatch_valid = 1; dispatch_rob_idx = 6'd13; addr_valid = 1; addr_sq_idx = 3'd2;
        tick();
        clear_inputs();
        total++; if (dispatch_sq_idx !== 3'd1) begin bad++; $display("FAIL flush_tail: got %0d want 1", dispatch_sq_idx); end
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || mem_req_data !== 32'hA0) begin bad++;
            $display("FAIL flush_head: got v%b %h %h want v1 200 a0", mem_req_valid, mem_req_addr, mem_req_data); end
        total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL flush_cready: got %b want 0", commit_ready); end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        total++; if (sq_empty !== 1'b1) begin bad++; $display("FAIL flush_count: got empty %b want 1", sq_empty); end
        dispatch(14);
        total++; if (dispatch_sq_idx !== 3'd2 || sq_empty !== 1'b0) begin bad++;
            $display("FAIL flush_redispatch: got idx %0d empty %b want 2 0", dispatch_sq_idx, sq_empty); end
    endtask

    task automatic run_batch(input int first, input int n);
        for (int s = first; s < first + n; s++) begin
            total++; if (dispatch_sq_idx !== 3'(s % 8)) begin bad++;
                $display("FAIL wrap_idx%0d: got %0d want %0d", s, dispatch_sq_idx, s % 8); end
            dispatch(s);
        end
        for (int s = first + n - 1; s >= first; s--)
            write_ad(s % 8, 32'h1000 + 32'(4 * s), 32'hC0DE0000 + 32'(s));
        for (int s = first; s < first + n; s++) begin
            total++; if (commit_ready !== 1'b1 || sq_full !== 1'b0) begin bad++;
                $display("FAIL wrap_commit%0d: got crdy %b full %b want 1 0", s, commit_ready, sq_full); end
            commit_one();
        end
        mem_req_ready = 1;
        for (int s = first; s < first + n; s++) begin
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 + 32'(4 * s) ||
                         mem_req_data !== 32'hC0DE0000 + 32'(s) || mem_req_rob_idx !== 6'(s)) begin bad++;
                $display("FAIL wrap_drain%0d: got v%b %h %h r%0d want v1 %h %h r%0d", s, mem_req_valid, mem_req_addr,
                         mem_req_data, mem_req_rob_idx, 32'h1000 + 32'(4 * s), 32'hC0DE0000 + 32'(s), s); end
            tick();
        end
        mem_req_ready = 0;
        total++; if (sq_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty%0d: got %b want 1", first, sq_empty); end
    endtask

    task automatic test_wrap();
        do_reset();
        run_batch(0, 5);
        run_batch(5, 7);
    endtask

    task automatic test_commit_wait();
        do_reset();
        dispatch(5);
        addr_valid = 1; addr_sq_idx = 3'd0; addr_in = 32'h300;
        data_valid = 1; data_sq_idx = 3'd1; data_in = 32'hBAD;
        tick();
        clear_inputs();
        total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL cwait_nodata: got %b want 0", commit_ready); end
        commit_one();
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL cwait_ignored: got %b want 0", mem_req_valid); end
        dispatch(6);
        data_valid = 1; data_sq_idx = 3'd0; data_in = 32'h77;
        tick();
        clear_inputs();
        total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL cwait_ready: got %b want 1", commit_ready); end
        commit_one();
        total++; if (mem_req_valid !== 1'b1 || mem_req_data !== 32'h77 || mem_req_addr !== 32'h300) begin bad++;
            $display("FAIL cwait_commit: got v%b %h %h want v1 300 77", mem_req_valid, mem_req_addr, mem_req_data); end
        addr_valid = 1; addr_sq_idx = 3'd1; addr_in = 32'h304;
        tick();
        clear_inputs();
        total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL cwait_stale: got %b want 0", commit_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dispatch(1);
        write_ad(0, 32'h400, 32'h1);
        commit_one();
        dispatch_valid = 1; dispatch_rob_idx = 6'd2; mem_req_ready = 1;
        tick();
        clear_inputs();
        total++; if (sq_empty !== 1'b0 || mem_req_valid !== 1'b0 || dispatch_sq_idx !== 3'd2) begin bad++;
            $display("FAIL b2b_swap: got empty %b memv %b idx %0d want 0 0 2", sq_empty, mem_req_valid, dispatch_sq_idx); end
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                total++; if (sq_full !== 1'b0) begin bad++; $display("FAIL b2b_notfull: got %b want 0", sq_full); end
            end
            dispatch(3 + i);
        end
        total++; if (sq_full !== 1'b1) begin bad++; $display("FAIL b2b_full: got %b want 1", sq_full); end
    endtask

    task automatic test_forward();
        logic        exp_hit;
        logic [31:0] exp_young, exp_third;
`ifdef STQ_FWD_EN
        exp_hit = 1'b1; exp_young = 32'h22; exp_third = 32'h33;
`else
        exp_hit = 1'b0; exp_young = 32'h0; exp_third = 32'h0;
`endif
        do_reset();
        dispatch(0); dispatch(1); dispatch(2);
        write_ad(0, 32'h40, 32'h11);
        write_ad(1, 32'h40, 32'h22);
        addr_valid = 1; addr_sq_idx = 3'd2; addr_in = 32'h40;
        tick();
        clear_inputs();
        ld_valid = 1; ld_addr = 32'h40;
        #1;
        total++; if (fwd_hit !== exp_hit || fwd_data !== exp_young) begin bad++;
            $display("FAIL fwd_young: got %b %h want %b %h", fwd_hit, fwd_data, exp_hit, exp_young); end
        ld_addr = 32'h44;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin bad++;
            $display("FAIL fwd_miss: got %b %h want 0 0", fwd_hit, fwd_data); end
        ld_valid = 0; ld_addr = 32'h40;
        #1;
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_noreq: got %b want 0", fwd_hit); end
        data_valid = 1; data_sq_idx = 3'd2; data_in = 32'h33;
        tick();
        clear_inputs();
        ld_valid = 1; ld_addr = 32'h40;
        #1;
        total++; if (fwd_hit !== exp_hit || fwd_data !== exp_third) begin bad++;
            $display("FAIL fwd_third: got %b %h want %b %h", fwd_hit, fwd_data, exp_hit, exp_third); end
        ld_valid = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 0;
        clear_inputs();
        test_reset();
        test_fill();
        test_drain_stall();
        test_flush();
        test_wrap();
        test_commit_wait();
        test_back_to_back();
        test_forward();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
